draw_rect_multi: RTL
====================

DRAW_RECT_MULTI -- requirements
Module: draw_rect_multi

Interface
REQ-001 SHALL have parameter N_RECT, default 4, number of rectangles (1..16).
REQ-002 SHALL have parameter COORD_W, default 11, pixel coordinate width.
REQ-003 SHALL have parameter COLOR_W, default 12, RGB colour width.
REQ-004 SHALL have port clk  input  1  sole clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port pix_x, pix_y  input  COORD_W  current pixel from VGA timing.
REQ-007 SHALL have port pix_valid  input  1  active-video qualifier.
REQ-008 SHALL have port frame_start  input  1  one-cycle pulse at frame start.
REQ-009 SHALL have port color_fondo  input  COLOR_W  background colour.
REQ-010 SHALL have port cfg_valid  input  1  config write request.
REQ-011 SHALL have port cfg_ready  output  1  config write accept.
REQ-012 SHALL have port cfg_idx  input  IDX_W=max(1,$clog2(N_RECT))  target rectangle.
REQ-013 SHALL have ports cfg_xmin, cfg_xmax, cfg_ymin, cfg_ymax  input  COORD_W  inclusive bounds.
REQ-014 SHALL have ports cfg_color  input  COLOR_W and cfg_en  input  1  fill colour, rectangle enable.
REQ-015 SHALL have ports rgb_out  output  COLOR_W, rgb_valid  output  1, hit  output  1, hit_idx  output  IDX_W.

Function
REQ-016 SHALL accept a config write when cfg_valid and cfg_ready are both high at a clk edge, storing all cfg_* fields into the shadow entry cfg_idx; cfg_idx >= N_RECT writes are accepted and discarded.
REQ-017 SHALL run a commit FSM: IDLE -> DIRTY on an accepted write; DIRTY -> COMMIT on frame_start; COMMIT -> IDLE unconditionally after one cycle.
REQ-018 SHALL copy every shadow entry to its active entry at the edge ending COMMIT; frame_start in IDLE or COMMIT SHALL cause no copy.
REQ-019 SHALL drive cfg_ready low only in COMMIT; a write accepted in the frame_start cycle SHALL be included in that commit.
REQ-020 SHALL register stage 1: per-rectangle hit = active en AND xmin<=pix_x<=xmax AND ymin<=pix_y<=ymax (unsigned), plus pix_valid.
REQ-021 SHALL register stage 2: lowest-index hitting rectangle wins; rgb_out = its colour, hit=1, hit_idx=its index; no hit -> rgb_out=color_fondo, hit=0, hit_idx=0.
REQ-022 SHALL give a fixed 2-cycle latency from pix_x/pix_y/pix_valid to rgb_out/rgb_valid/hit; rgb_valid = pix_valid delayed 2.
REQ-023 SHALL output rgb_out=0, hit=0, hit_idx=0 when the delayed pix_valid is low (blanking).
REQ-024 SHALL treat xmin>xmax or ymin>ymax as never hitting; xmin==xmax SHALL hit a one-pixel-wide column.

Reset
REQ-025 SHALL, while rst_n low, clear shadow and active entries (en=0, bounds 0, colour 0), FSM=IDLE, rgb_out=0, rgb_valid=0, hit=0, hit_idx=0, cfg_ready=0.
REQ-026 SHALL assert cfg_ready on the first edge after rst_n release; reset mid-COMMIT SHALL abandon the copy.

Configuration
REQ-027 SHALL, with DRAW_RECT_BORDER_EN defined, add input cfg_border (1) and parameter BORDER_W (default 2); a border-mode rectangle hits only pixels within BORDER_W of any edge, interior falls through to lower priority or background.
REQ-028 SHALL, without DRAW_RECT_BORDER_EN, omit cfg_border and BORDER_W and fill all rectangles solid.

Structure
REQ-029 SHALL place the rect_cfg_t struct (bounds, colour, en, border) and the FSM state enum in package draw_rect_pkg.
REQ-030 SHALL instantiate sub-module rect_hit, one per rectangle, performing the stage-1 bounds/border compare.

Verification
REQ-031 SHALL cover: write rect0 (10..20,10..20,colour 0xF00,en) + frame_start; pixel (15,15) -> two cycles later rgb_out=0xF00, hit=1, hit_idx=0.
REQ-032 SHALL cover: rect0 and rect1 (0xF00 and 0x0F0) both covering (5,5) -> rgb_out=0xF00, hit_idx=0; disable rect0, commit -> 0x0F0, hit_idx=1.
REQ-033 SHALL cover: write without frame_start -> output unchanged; after frame_start, cfg_ready low exactly 1 cycle, new colour from the next frame.
REQ-034 SHALL cover: pixels (9,10), (10,10), (20,20), (21,20) -> background, hit, hit, background; rect xmin=30,xmax=25 -> never hits.
REQ-035 SHALL cover: pix_valid low -> rgb_out=0, rgb_valid=0 after 2 cycles; rst_n pulse mid-frame -> all outputs 0, prior config lost.
REQ-036 SHALL cover (DRAW_RECT_BORDER_EN): border rect 0..9, BORDER_W=2 -> (1,5) hits, (5,5) returns background.

Source files
------------

// File: rtl/draw_rect_pkg.sv
// draw_rect_pkg: shared rectangle config record, commit FSM states and sizing helper
package draw_rect_pkg;

    // Storage widths for the config record; top-level COORD_W/COLOR_W must not exceed these
    localparam int MAX_COORD_W = 16;
    localparam int MAX_COLOR_W = 24;

    typedef struct packed {
        logic [MAX_COORD_W-1:0] xmin;
        logic [MAX_COORD_W-1:0] xmax;
        logic [MAX_COORD_W-1:0] ymin;
        logic [MAX_COORD_W-1:0] ymax;
        logic [MAX_COLOR_W-1:0] color;
        logic                   en;
        logic                   border;
    } rect_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIRTY,
        ST_COMMIT
    } commit_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rect_hit.sv
// rect_hit: stage-1 inclusive bounds compare for one rectangle; border mode when DRAW_RECT_BORDER_EN is defined
module rect_hit
    import draw_rect_pkg::*;
`ifdef DRAW_RECT_BORDER_EN
#(
    parameter int BORDER_W = 2
)
`endif
(
    input  rect_cfg_t              i_cfg,
    input  logic [MAX_COORD_W-1:0] i_x,
    input  logic [MAX_COORD_W-1:0] i_y,
    output logic                   o_hit
);

    logic w_inside;

    // Inverted bounds (min > max) can never satisfy both compares, so they never hit
    assign w_inside = i_cfg.en
                   && (i_x >= i_cfg.xmin) && (i_x <= i_cfg.xmax)
                   && (i_y >= i_cfg.ymin) && (i_y <= i_cfg.ymax);

`ifdef DRAW_RECT_BORDER_EN
    localparam logic [MAX_COORD_W-1:0] BW = MAX_COORD_W'(BORDER_W);

    logic w_edge;

    // Distances are only meaningful when inside, where the subtractions cannot wrap
    assign w_edge = ((i_x - i_cfg.xmin) < BW) || ((i_cfg.xmax - i_x) < BW)
                 || ((i_y - i_cfg.ymin) < BW) || ((i_cfg.ymax - i_y) < BW);

    assign o_hit = w_inside && (!i_cfg.border || w_edge);
`else
    logic w_unused_border;

    assign w_unused_border = i_cfg.border;
    assign o_hit           = w_inside;
`endif

endmodule

// File: rtl/draw_rect_multi.sv
// draw_rect_multi: priority overlay of N_RECT rectangles on a VGA pixel stream, config committed at frame start
// Define DRAW_RECT_BORDER_EN to add cfg_border and BORDER_W (outline-only rectangles).
module draw_rect_multi
    import draw_rect_pkg::*;
#(
    parameter  int N_RECT   = 4,
    parameter  int COORD_W  = 11,
    parameter  int COLOR_W  = 12,
`ifdef DRAW_RECT_BORDER_EN
    parameter  int BORDER_W = 2,
`endif
    localparam int IDX_W    = idx_width(N_RECT)
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               pix_valid,
    input  logic               frame_start,
    input  logic [COLOR_W-1:0] color_fondo,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [COORD_W-1:0] cfg_xmin,
    input  logic [COORD_W-1:0] cfg_xmax,
    input  logic [COORD_W-1:0] cfg_ymin,
    input  logic [COORD_W-1:0] cfg_ymax,
    input  logic [COLOR_W-1:0] cfg_color,
    input  logic               cfg_en,
`ifdef DRAW_RECT_BORDER_EN
    input  logic               cfg_border,
`endif
    output logic [COLOR_W-1:0] rgb_out,
    output logic               rgb_valid,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_idx
);

    rect_cfg_t              r_shadow [N_RECT];
    rect_cfg_t              r_active [N_RECT];
    commit_state_t          r_state;
    logic                   r_cfg_ready;
    logic [N_RECT-1:0]      r_hit_vec;
    logic                   r_valid1;
    logic                   r_valid2;
    logic [COLOR_W-1:0]     r_rgb;
    logic                   r_hit;
    logic [IDX_W-1:0]       r_hit_idx;

    logic                   w_accept;
    logic                   w_wr_border;
    rect_cfg_t              w_wr_cfg;
    logic [MAX_COORD_W-1:0] w_x;
    logic [MAX_COORD_W-1:0] w_y;
    logic [N_RECT-1:0]      w_hit_vec;
    logic                   w_found;
    logic [IDX_W-1:0]       w_sel_idx;
    logic [COLOR_W-1:0]     w_sel_color;

`ifdef DRAW_RECT_BORDER_EN
    assign w_wr_border = cfg_border;
`else
    assign w_wr_border = 1'b0;
`endif

    assign w_accept = cfg_valid && r_cfg_ready;
    assign w_wr_cfg = '{xmin:   MAX_COORD_W'(cfg_xmin),
                        xmax:   MAX_COORD_W'(cfg_xmax),
                        ymin:   MAX_COORD_W'(cfg_ymin),
                        ymax:   MAX_COORD_W'(cfg_ymax),
                        color:  MAX_COLOR_W'(cfg_color),
                        en:     cfg_en,
                        border: w_wr_border};
    assign w_x      = MAX_COORD_W'(pix_x);
    assign w_y      = MAX_COORD_W'(pix_y);

    // Shadow takes accepted writes (out-of-range indices match no entry); active reloads from shadow as COMMIT ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_RECT; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_RECT; i++) begin
                if (w_accept && (cfg_idx == IDX_W'(i)))
                    r_shadow[i] <= w_wr_cfg;
                if (r_state == ST_COMMIT)
                    r_active[i] <= r_shadow[i];
            end
        end
    end

    // Commit FSM with registered ready: low only for the single COMMIT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cfg_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cfg_ready <= 1'b1;
                    if (w_accept)
                        r_state <= ST_DIRTY;
                end
                ST_DIRTY: begin
                    r_cfg_ready <= !frame_start;
                    if (frame_start)
                        r_state <= ST_COMMIT;
                end
                default: begin
                    r_cfg_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar r = 0; r < N_RECT; r++) begin : g_rect
`ifdef DRAW_RECT_BORDER_EN
        rect_hit #(.BORDER_W(BORDER_W)) u_hit (
`else
        rect_hit u_hit (
`endif
            .i_cfg (r_active[r]),
            .i_x   (w_x),
            .i_y   (w_y),
            .o_hit (w_hit_vec[r])
        );
    end

    // Stage 1: capture per-rectangle hits alongside the pixel qualifier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_vec <= '0;
            r_valid1  <= 1'b0;
        end else begin
            r_hit_vec <= w_hit_vec;
            r_valid1  <= pix_valid;
        end
    end

    // Lowest index wins: scan from the top so lower indices overwrite higher ones
    always_comb begin
        w_found     = 1'b0;
        w_sel_idx   = '0;
        w_sel_color = '0;
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if (r_hit_vec[i]) begin
                w_found     = 1'b1;
                w_sel_idx   = IDX_W'(i);
                w_sel_color = COLOR_W'(r_active[i].color);
            end
        end
    end

    // Stage 2: resolve colour, blanking forces all pixel outputs to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid2  <= 1'b0;
            r_hit     <= 1'b0;
            r_hit_idx <= '0;
            r_rgb     <= '0;
        end else begin
            r_valid2  <= r_valid1;
            r_hit     <= r_valid1 && w_found;
            r_hit_idx <= r_valid1 ? w_sel_idx : '0;
            r_rgb     <= !r_valid1 ? '0 : (w_found ? w_sel_color : color_fondo);
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign rgb_out   = r_rgb;
    assign rgb_valid = r_valid2;
    assign hit       = r_hit;
    assign hit_idx   = r_hit_idx;

endmodule
